// File: rtl/writeback_unit_if.sv
// writeback_unit_if: MEM/WB boundary and register-file write-port bundle for writeback_unit.
interface writeback_unit_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 64
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  wb_stall;
   logic                  flush;
   logic [1:0]            wb_sel;
   logic [XLEN-1:0]       alu_result;
   logic [XLEN-1:0]       mem_data_out;
   logic [XLEN-1:0]       pc_plus4;
   logic [XLEN-1:0]       csr_rdata;
   logic [2:0]            load_funct3;
   logic [1:0]            addr_lo;
   logic [REG_ADDR_W-1:0] rd_out;
   logic                  reg_write;
   logic [XLEN-1:0]       wb_data;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  wb_reg_write;
   logic                  wb_valid;
   logic [CNT_W-1:0]      retire_count;
   modport master (
      output in_valid, wb_stall, flush, wb_sel, alu_result, mem_data_out, pc_plus4, csr_rdata,
             load_funct3, addr_lo, rd_out, reg_write,
      input  in_ready, wb_data, wb_rd, wb_reg_write, wb_valid, retire_count
   );
   modport slave (
      input  in_valid, wb_stall, flush, wb_sel, alu_result, mem_data_out, pc_plus4, csr_rdata,
             load_funct3, addr_lo, rd_out, reg_write,
      output in_ready, wb_data, wb_rd, wb_reg_write, wb_valid, retire_count
   );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB writeback stage with load formatting, stall/flush and x0 write suppress.
// Define WB_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retire_count is 0.
module writeback_unit #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 64
) (
   input logic             clk,
   input logic             rst_n,
   writeback_unit_if.slave bus
);
   logic                  acc;
   logic [7:0]            ld_b;
   logic [15:0]           ld_h;
   logic [31:0]           ld_w;
   logic [XLEN-1:0]       ld_data, res, data_q, data_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic                  we_q, we_d, valid_q, valid_d;
   always_comb begin
      acc     = bus.in_valid & ~bus.wb_stall & ~bus.flush;
      ld_b    = bus.mem_data_out[{bus.addr_lo, 3'b000} +: 8];
      ld_h    = bus.mem_data_out[{bus.addr_lo[1], 4'b0000} +: 16];
      ld_w    = bus.mem_data_out[31:0];
      ld_data = bus.load_funct3 == 3'd0 ? XLEN'($signed(ld_b)) :
                bus.load_funct3 == 3'd4 ? XLEN'(ld_b) :
                bus.load_funct3 == 3'd1 ? XLEN'($signed(ld_h)) :
                bus.load_funct3 == 3'd5 ? XLEN'(ld_h) :
                bus.load_funct3 == 3'd2 ? XLEN'($signed(ld_w)) : bus.mem_data_out;
      res     = bus.wb_sel == 2'd0 ? bus.alu_result :
                bus.wb_sel == 2'd1 ? ld_data :
                bus.wb_sel == 2'd2 ? bus.pc_plus4 : bus.csr_rdata;
      // data/rd hold unless accepted; valid/we clear on bubbles but freeze under stall
      data_d  = acc ? res : data_q;
      rd_d    = acc ? bus.rd_out : rd_q;
      valid_d = bus.wb_stall ? valid_q : acc;
      we_d    = bus.wb_stall ? we_q : acc & bus.reg_write & (|bus.rd_out);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         valid_q <= valid_d;
      end
   end
   assign bus.in_ready     = ~bus.wb_stall;
   assign bus.wb_data      = data_q;
   assign bus.wb_rd        = rd_q;
   assign bus.wb_reg_write = we_q;
   assign bus.wb_valid     = valid_q;
`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = acc ? cnt_q + CNT_W'(1) : cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign bus.retire_count = cnt_q;
`else
   assign bus.retire_count = '0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard bench for writeback_unit with directed and random stimulus.
module tb_writeback_unit;
   localparam int XLEN = 32, RW = 5, CW = 4;
`ifdef WB_RETIRE_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif
   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        val;
      logic [3:0]  cnt;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   exp_t q[$];
   logic [31:0] m_data;
   logic [4:0]  m_rd;
   logic        m_we, m_val;
   int          m_acc;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   writeback_unit_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) bus();
   writeback_unit #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] fmt(logic [1:0] sel, logic [31:0] alu, mem, pc, csr,
                                       logic [2:0] f3, logic [1:0] lo);
      longint w, v;
      w = longint'(mem);
      if (sel == 2'd0) return alu;
      if (sel == 2'd2) return pc;
      if (sel == 2'd3) return csr;
      case (f3)
         3'd0: begin v = (w >> (8 * int'(lo))) & 255; if (v > 127) v -= 256; return 32'(v); end
         3'd4: return 32'((w >> (8 * int'(lo))) & 255);
         3'd1: begin v = (w >> (16 * (int'(lo) / 2))) & 65535; if (v > 32767) v -= 65536; return 32'(v); end
         3'd5: return 32'((w >> (16 * (int'(lo) / 2))) & 65535);
         default: return mem;
      endcase
   endfunction
   task automatic drive(logic v, logic st, logic fl, logic [1:0] sel, logic [31:0] alu, mem, pc, csr,
                        logic [2:0] f3, logic [1:0] lo, logic [4:0] rd, logic rw);
      exp_t e;
      bus.in_valid = v; bus.wb_stall = st; bus.flush = fl; bus.wb_sel = sel;
      bus.alu_result = alu; bus.mem_data_out = mem; bus.pc_plus4 = pc; bus.csr_rdata = csr;
      bus.load_funct3 = f3; bus.addr_lo = lo; bus.rd_out = rd; bus.reg_write = rw;
      #1 chk("in_ready", 32'(bus.in_ready), 32'(!st));
      if (!st) begin
         if (v && !fl) begin
            m_data = fmt(sel, alu, mem, pc, csr, f3, lo);
            m_rd   = rd;
            m_we   = rw && rd != 0;
            m_val  = 1'b1;
            m_acc++;
         end else begin
            m_val = 1'b0;
            m_we  = 1'b0;
         end
      end
      e.cyc = cyc + 1; e.data = m_data; e.rd = m_rd; e.we = m_we; e.val = m_val;
      e.cnt = CNT_ON ? 4'(m_acc) : 4'd0;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic rnd_cycle();
      drive($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
            2'($urandom), $urandom, $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom),
            5'($urandom), 1'($urandom));
   endtask
   task automatic model_reset();
      m_data = '0; m_rd = '0; m_we = 1'b0; m_val = 1'b0; m_acc = 0;
   endtask
   initial begin : monitor
      forever begin
         @(negedge clk);
         while (rst_n && q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("wb_data", bus.wb_data, e.data);
            chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
            chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(e.we));
            chk("wb_valid", 32'(bus.wb_valid), 32'(e.val));
            chk("retire_count", 32'(bus.retire_count), 32'(e.cnt));
         end
      end
   end
   initial begin : stim
      model_reset();
      bus.in_valid = 0; bus.wb_stall = 0; bus.flush = 0; bus.wb_sel = 0;
      bus.alu_result = 0; bus.mem_data_out = 0; bus.pc_plus4 = 0; bus.csr_rdata = 0;
      bus.load_funct3 = 0; bus.addr_lo = 0; bus.rd_out = 0; bus.reg_write = 0;
      #3;
      chk("rst_data", bus.wb_data, 0);
      chk("rst_rd", 32'(bus.wb_rd), 0);
      chk("rst_we", 32'(bus.wb_reg_write), 0);
      chk("rst_valid", 32'(bus.wb_valid), 0);
      chk("rst_cnt", 32'(bus.retire_count), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (14) drive(1, 0, 0, 0, $urandom, 0, 0, 0, 0, 0, 5'd1, 1);
      chk("cnt_14", 32'(bus.retire_count), CNT_ON ? 14 : 0);
      drive(1, 0, 0, 0, 32'h11, 0, 0, 0, 0, 0, 5'd2, 1);
      chk("cnt_15", 32'(bus.retire_count), CNT_ON ? 15 : 0);
      drive(1, 0, 1, 0, 32'h22, 0, 0, 0, 0, 0, 5'd2, 1);
      chk("cnt_flush", 32'(bus.retire_count), CNT_ON ? 15 : 0);
      drive(1, 0, 0, 0, 32'h33, 0, 0, 0, 0, 0, 5'd2, 1);
      chk("cnt_wrap", 32'(bus.retire_count), 0);
      drive(1, 0, 0, 1, 0, 32'h80FF7F01, 0, 0, 3'd0, 2'd3, 5'd4, 1);
      chk("lb_3", bus.wb_data, 32'hFFFFFF80);
      drive(1, 0, 0, 1, 0, 32'h80FF7F01, 0, 0, 3'd4, 2'd1, 5'd4, 1);
      chk("lbu_1", bus.wb_data, 32'h0000007F);
      drive(1, 0, 0, 1, 0, 32'h80FF7F01, 0, 0, 3'd1, 2'd2, 5'd4, 1);
      chk("lh_2", bus.wb_data, 32'hFFFF80FF);
      drive(1, 0, 0, 1, 0, 32'h80FF7F01, 0, 0, 3'd5, 2'd0, 5'd4, 1);
      chk("lhu_0", bus.wb_data, 32'h00007F01);
      drive(1, 0, 0, 0, 32'd5, 0, 0, 0, 0, 0, 5'd0, 1);
      chk("x0_valid", 32'(bus.wb_valid), 1);
      chk("x0_we", 32'(bus.wb_reg_write), 0);
      chk("x0_data", bus.wb_data, 5);
      drive(1, 0, 0, 2, 0, 0, 32'h100, 0, 0, 0, 5'd7, 1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, i == 1, 2, 0, 0, 32'h200, 0, 0, 0, 5'd9, 1);
         chk("stall_data", bus.wb_data, 32'h100);
         chk("stall_rd", 32'(bus.wb_rd), 7);
         chk("stall_we", 32'(bus.wb_reg_write), 1);
      end
      drive(1, 0, 1, 2, 0, 0, 32'h300, 0, 0, 0, 5'd9, 1);
      chk("flush_valid", 32'(bus.wb_valid), 0);
      chk("flush_we", 32'(bus.wb_reg_write), 0);
      drive(1, 0, 0, 0, 32'hA, 32'hB, 32'hC, 32'hD, 3'd2, 0, 5'd3, 1);
      chk("mux_alu", bus.wb_data, 32'hA);
      drive(1, 0, 0, 1, 32'hA, 32'hB, 32'hC, 32'hD, 3'd2, 0, 5'd3, 1);
      chk("mux_load", bus.wb_data, 32'hB);
      drive(1, 0, 0, 2, 32'hA, 32'hB, 32'hC, 32'hD, 3'd2, 0, 5'd3, 1);
      chk("mux_pc", bus.wb_data, 32'hC);
      drive(1, 0, 0, 3, 32'hA, 32'hB, 32'hC, 32'hD, 3'd2, 0, 5'd3, 1);
      chk("mux_csr", bus.wb_data, 32'hD);
      repeat (400) rnd_cycle();
      drive(1, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 0, 5'd3, 1);
      chk("pre_reset_data", bus.wb_data, 32'h1234);
      rst_n = 1'b0;
      #1;
      chk("async_rst_data", bus.wb_data, 0);
      chk("async_rst_rd", 32'(bus.wb_rd), 0);
      chk("async_rst_we", 32'(bus.wb_reg_write), 0);
      chk("async_rst_valid", 32'(bus.wb_valid), 0);
      chk("async_rst_cnt", 32'(bus.retire_count), 0);
      q.delete();
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (40) rnd_cycle();
      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
